// File: rtl/seq_checker.sv
// On-line integrity monitor for a WIDTH-bit reflected-Gray sequence stream with direction input.
// Optional mismatch capture registers are enabled by defining SEQ_CHK_CAPTURE_EN.
module seq_checker #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] state_in,
  input  logic             dir_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] err_count
`ifdef SEQ_CHK_CAPTURE_EN
  ,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_exp,
  output logic [WIDTH-1:0] cap_act
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
  localparam logic [BW-1:0] LOSS_V = BW'(LOSS_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [GW-1:0]    good_cnt_r, good_cnt_nxt_s;
  logic [BW-1:0]    bad_cnt_r, bad_cnt_nxt_s;
  logic [WIDTH-1:0] prev_state_r;
  logic             prev_dir_r;
  logic             locked_r, err_pulse_r, wrap_pulse_r;
  logic             err_pulse_nxt_s, wrap_pulse_nxt_s;
  logic [CNT_W-1:0] err_count_r, err_count_nxt_s;
  logic [WIDTH-1:0] prev_bin_s, next_bin_s, exp_s;
  logic             match_s, wrap_s, miss_locked_s;

  // Prediction of the next Gray state from the previous sample and its direction
  always_comb begin
    prev_bin_s = gray2bin(prev_state_r);
    if (prev_dir_r) begin
      next_bin_s = prev_bin_s + WIDTH'(1);
      wrap_s     = (prev_bin_s == {WIDTH{1'b1}});
    end else begin
      next_bin_s = prev_bin_s - WIDTH'(1);
      wrap_s     = (prev_bin_s == {WIDTH{1'b0}});
    end
    exp_s         = bin2gray(next_bin_s);
    match_s       = (state_in == exp_s);
    miss_locked_s = valid_in && (state_r == LOCKED) && !match_s;
  end

  // Lock FSM next-state and per-sample pulse decode
  always_comb begin
    state_nxt_s      = state_r;
    good_cnt_nxt_s   = good_cnt_r;
    bad_cnt_nxt_s    = bad_cnt_r;
    err_pulse_nxt_s  = 1'b0;
    wrap_pulse_nxt_s = 1'b0;
    if (valid_in) begin
      case (state_r)
        HUNT: begin
          state_nxt_s    = SYNC;
          good_cnt_nxt_s = '0;
          bad_cnt_nxt_s  = '0;
        end
        SYNC: begin
          if (!match_s) begin
            good_cnt_nxt_s = '0;
          end else if (good_cnt_r + GW'(1) == LOCK_V) begin
            state_nxt_s    = LOCKED;
            good_cnt_nxt_s = '0;
            bad_cnt_nxt_s  = '0;
          end else begin
            good_cnt_nxt_s = good_cnt_r + GW'(1);
          end
        end
        LOCKED: begin
          if (match_s) begin
            bad_cnt_nxt_s    = '0;
            wrap_pulse_nxt_s = wrap_s;
          end else begin
            err_pulse_nxt_s = 1'b1;
            if (bad_cnt_r + BW'(1) == LOSS_V) begin
              state_nxt_s   = HUNT;
              bad_cnt_nxt_s = '0;
            end else begin
              bad_cnt_nxt_s = bad_cnt_r + BW'(1);
            end
          end
        end
        default: begin
          state_nxt_s    = HUNT;
          good_cnt_nxt_s = '0;
          bad_cnt_nxt_s  = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Saturating error counter; a clear outranks a coincident miss
  always_comb begin
    if (err_clr) begin
      err_count_nxt_s = '0;
    end else if (miss_locked_s && (err_count_r != {CNT_W{1'b1}})) begin
      err_count_nxt_s = err_count_r + CNT_W'(1);
    end else begin
      err_count_nxt_s = err_count_r;
    end
  end

  // State, history and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= HUNT;
      good_cnt_r   <= '0;
      bad_cnt_r    <= '0;
      prev_state_r <= '0;
      prev_dir_r   <= 1'b0;
      locked_r     <= 1'b0;
      err_pulse_r  <= 1'b0;
      wrap_pulse_r <= 1'b0;
      err_count_r  <= '0;
    end else begin
      state_r      <= state_nxt_s;
      good_cnt_r   <= good_cnt_nxt_s;
      bad_cnt_r    <= bad_cnt_nxt_s;
      locked_r     <= (state_nxt_s == LOCKED);
      err_pulse_r  <= err_pulse_nxt_s;
      wrap_pulse_r <= wrap_pulse_nxt_s;
      err_count_r  <= err_count_nxt_s;
      if (valid_in) begin
        prev_state_r <= state_in;
        prev_dir_r   <= dir_in;
      end else begin
        prev_state_r <= prev_state_r;
        prev_dir_r   <= prev_dir_r;
      end
    end
  end

  assign locked     = locked_r;
  assign err_pulse  = err_pulse_r;
  assign wrap_pulse = wrap_pulse_r;
  assign err_count  = err_count_r;

`ifdef SEQ_CHK_CAPTURE_EN
  logic             cap_valid_r;
  logic [WIDTH-1:0] cap_exp_r, cap_act_r;

  // First locked miss since reset or clear is held until the next clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_valid_r <= 1'b0;
      cap_exp_r   <= '0;
      cap_act_r   <= '0;
    end else if (err_clr) begin
      cap_valid_r <= 1'b0;
      cap_exp_r   <= '0;
      cap_act_r   <= '0;
    end else if (miss_locked_s && !cap_valid_r) begin
      cap_valid_r <= 1'b1;
      cap_exp_r   <= exp_s;
      cap_act_r   <= state_in;
    end else begin
      cap_valid_r <= cap_valid_r;
    end
  end

  assign cap_valid = cap_valid_r;
  assign cap_exp   = cap_exp_r;
  assign cap_act   = cap_act_r;
`endif

endmodule
